// File: rtl/stream_101_scheduler_pkg.sv
// Purpose : shared types, defaults and the "101" detector step function.
// Latency : n/a (types and a pure combinational function).
// Backpressure: n/a.
package stream_101_scheduler_pkg;

  localparam int DEF_NCH = 4;
  localparam int DEF_CW  = 8;

  // Per-channel detector context. ST_RSVD is never produced and behaves like ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_1    = 2'd1,
    ST_10   = 2'd2,
    ST_RSVD = 2'd3
  } state_t;

  // Returns {match, next_state}. Detection overlaps: the closing '1' of a
  // "101" is also the opening '1' of the next candidate.
  function automatic logic [2:0] next_state(input state_t s, input logic b);
    logic [2:0] r;
    case (s)
      ST_1:    r = b ? {1'b0, ST_1} : {1'b0, ST_10};
      ST_10:   r = b ? {1'b1, ST_1} : {1'b0, ST_IDLE};
      default: r = b ? {1'b0, ST_1} : {1'b0, ST_IDLE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stream_101_scheduler_if.sv
// Purpose : request/data/readout bundle between front-ends and the scheduler.
// Latency : n/a (wires only).
// Backpressure: iREQ/iBIT held by the requester until oGNT is seen.
// Ports   : iREQ/iBIT per-channel request+bit, iFLUSH clear, iSEL counter select;
//           oGNT one-hot grant, oMATCH/oMATCH_CH match pulse, oCOUNT selected count.
interface stream_101_scheduler_if #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int CW  = 8
) ();

  logic [NCH-1:0] iREQ;
  logic [NCH-1:0] iBIT;
  logic           iFLUSH;
  logic [CHW-1:0] iSEL;
  logic [NCH-1:0] oGNT;
  logic           oMATCH;
  logic [CHW-1:0] oMATCH_CH;
  logic [CW-1:0]  oCOUNT;

  // master: the front-end / readout side driving requests
  modport master (
    output iREQ, iBIT, iFLUSH, iSEL,
    input  oGNT, oMATCH, oMATCH_CH, oCOUNT
  );

  // slave: the scheduler
  modport slave (
    input  iREQ, iBIT, iFLUSH, iSEL,
    output oGNT, oMATCH, oMATCH_CH, oCOUNT
  );

endinterface

// File: rtl/stream_101_scheduler_rr_arbiter_nch.sv
// Purpose : round-robin arbiter, searches ptr+1..ptr+NCH (mod NCH), one-hot grant.
// Latency : grant is combinational; pointer moves on the edge of a grant cycle.
// Backpressure: none internal; i_adv=0 freezes the pointer.
// Ports   : i_clk, i_rst (sync, active-high), i_req, i_adv; o_gnt, o_id, o_vld.
module rr_arbiter_nch #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [NCH-1:0] i_req,
  input  logic           i_adv,
  output logic [NCH-1:0] o_gnt,
  output logic [CHW-1:0] o_id,
  output logic           o_vld
);

  logic [CHW-1:0] r_ptr;
  logic [CHW-1:0] w_idx;

  // Scan from the channel after the last winner; first requester wins.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_vld = 1'b0;
    w_idx = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_idx = CHW'((int'(r_ptr) + k) % NCH);
      if (!o_vld && i_req[w_idx]) begin
        o_vld        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

  // Reset to NCH-1 so channel 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= CHW'(NCH - 1);
    end else if (i_adv && o_vld) begin
      r_ptr <= o_id;
    end
  end

endmodule

// File: rtl/stream_101_scheduler.sv
// Purpose : one shared "101" detector time-multiplexed over NCH bitstreams,
//           with per-channel saved context and saturating match counters.
// Latency : bit consumed on grant cycle t; oMATCH/oMATCH_CH valid at t+1.
// Backpressure: requester holds iREQ/iBIT until oGNT; grants masked during iRST/iFLUSH.
// Ports   : iCLK, iRST (sync, active-high); bus (slave modport) carries
//           iREQ/iBIT/iFLUSH/iSEL in and oGNT/oMATCH/oMATCH_CH/oCOUNT out.
module stream_101_scheduler
  import stream_101_scheduler_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int CHW = 2,
  parameter int CW  = DEF_CW
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  stream_101_scheduler_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_t         r_ctx [NCH];
  logic [CW-1:0]  r_cnt [NCH];
  logic           r_match;
  logic [CHW-1:0] r_match_ch;

  logic           w_hold;
  logic [NCH-1:0] w_req;
  logic [NCH-1:0] w_gnt;
  logic [CHW-1:0] w_id;
  logic           w_vld;
  logic [2:0]     w_step;
  logic           w_match;

  // No bit may be consumed while contexts are being cleared.
  assign w_hold = iRST | bus.iFLUSH;
  assign w_req  = w_hold ? '0 : bus.iREQ;

  rr_arbiter_nch #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .i_clk (iCLK),
    .i_rst (iRST),
    .i_req (w_req),
    .i_adv (~w_hold),
    .o_gnt (w_gnt),
    .o_id  (w_id),
    .o_vld (w_vld)
  );

  // Restore the granted channel's context and step it with its bit.
  assign w_step  = next_state(r_ctx[w_id], bus.iBIT[w_id]);
  assign w_match = w_vld & w_step[2];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < NCH; i++) begin
        r_ctx[i] <= ST_IDLE;
        r_cnt[i] <= '0;
      end
      r_match    <= 1'b0;
      r_match_ch <= '0;
    end else if (bus.iFLUSH) begin
      for (int i = 0; i < NCH; i++) begin
        r_ctx[i] <= ST_IDLE;
        r_cnt[i] <= '0;
      end
      r_match <= 1'b0;
    end else begin
      r_match <= w_match;
      if (w_vld) begin
        r_ctx[w_id] <= state_t'(w_step[1:0]);
        r_match_ch  <= w_id;
        if (w_match && (r_cnt[w_id] != CNT_MAX)) begin
          r_cnt[w_id] <= r_cnt[w_id] + CW'(1);
        end
      end
    end
  end

  assign bus.oGNT      = w_gnt;
  assign bus.oMATCH    = r_match;
  assign bus.oMATCH_CH = r_match_ch;
  // Registered counters: a same-cycle read sees the pre-increment value.
  assign bus.oCOUNT    = (int'(bus.iSEL) < NCH) ? r_cnt[bus.iSEL] : '0;

endmodule

// File: tb/tb_stream_101_scheduler.sv
`timescale 1ns/1ps
module tb_stream_101_scheduler;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  stream_101_scheduler_if #(.NCH(4), .CHW(2), .CW(2)) bus ();

  stream_101_scheduler #(.NCH(4), .CHW(2), .CW(2)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #10 iCLK = ~iCLK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct { int due; int ch; } exp_t;
  exp_t exp_q[$];

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every expected match must appear on its due cycle,
  // and any other oMATCH pulse is an error.
  always @(negedge iCLK) begin
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check("match_vld", int'(bus.oMATCH), 1);
      check("match_ch", int'(bus.oMATCH_CH), e.ch);
    end else if (bus.oMATCH === 1'b1) begin
      check("spurious_match", int'(bus.oMATCH), 0);
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input logic [3:0] req, input logic [3:0] bits, input logic flush,
                       input logic [3:0] exp_gnt, input bit exp_m, input int exp_ch,
                       input string tag);
    bus.iREQ   = req;
    bus.iBIT   = bits;
    bus.iFLUSH = flush;
    @(negedge iCLK);
    check({tag, "_gnt"}, int'(bus.oGNT), int'(exp_gnt));
    if (exp_m) exp_q.push_back('{due: cyc + 1, ch: exp_ch});
    @(posedge iCLK);
    #1;
    bus.iREQ   = '0;
    bus.iFLUSH = 1'b0;
  endtask

  task automatic chk_cnt(input int ch, input int exp, input string tag);
    bus.iSEL = 2'(ch);
    #1;
    check($sformatf("%s_cnt%0d", tag, ch), int'(bus.oCOUNT), exp);
  endtask

  task automatic do_reset();
    iRST       = 1'b1;
    bus.iREQ   = 4'hF;
    bus.iBIT   = 4'h0;
    bus.iFLUSH = 1'b0;
    @(negedge iCLK);
    check("rst_gnt0", int'(bus.oGNT), 0);
    @(posedge iCLK); #1;
    @(negedge iCLK);
    check("rst_gnt1", int'(bus.oGNT), 0);
    check("rst_match", int'(bus.oMATCH), 0);
    @(posedge iCLK); #1;
    iRST     = 1'b0;
    bus.iREQ = '0;
  endtask

  task automatic idle(input int n);
    bus.iREQ = '0;
    repeat (n) begin @(posedge iCLK); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] p;
    bus.iREQ = '0; bus.iBIT = '0; bus.iFLUSH = 1'b0; bus.iSEL = '0;
    @(posedge iCLK); #1;

    // 1. Reset, then channel 0 has first priority; counters read zero.
    do_reset();
    drive(4'hF, 4'h0, 1'b0, 4'b0001, 0, 0, "t1_first");
    for (int c = 0; c < 4; c++) chk_cnt(c, 0, "t1");
    idle(2);

    // 2. Single stream on ch0: 1,0,1,0,1 -> matches on 3rd and 5th bit.
    do_reset();
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 0, 0, "t2_b0");
    drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 0, "t2_b1");
    chk_cnt(0, 0, "t2_pre");
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, "t2_b2");
    drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 0, "t2_b3");
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, "t2_b4");
    chk_cnt(0, 2, "t2");
    idle(2);

    // 3. All request: grants rotate 0,1,2,3; ch2 sees 1,0,1, others all 1.
    do_reset();
    p = 3'b101;
    for (int i = 0; i < 12; i++) begin
      logic [3:0] b;
      b = 4'b1011;
      b[2] = p[i/4];
      drive(4'hF, b, 1'b0, 4'(1 << (i % 4)), (i == 10), 2, $sformatf("t3_c%0d", i));
    end
    chk_cnt(0, 0, "t3"); chk_cnt(1, 0, "t3"); chk_cnt(2, 1, "t3"); chk_cnt(3, 0, "t3");
    idle(2);

    // 4. Context isolation: ch0 1,0 ; ch1 1 ; ch0 1 -> match only on ch0.
    do_reset();
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 0, 0, "t4_a");
    drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 0, "t4_b");
    drive(4'b0010, 4'b0010, 1'b0, 4'b0010, 0, 1, "t4_c");
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, "t4_d");
    chk_cnt(1, 0, "t4"); chk_cnt(0, 1, "t4");
    idle(2);

    // 5. Flush mid-pattern discards "10" on ch0.
    do_reset();
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 0, 0, "t5_a");
    drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 0, "t5_b");
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000, 0, 0, "t5_flush");
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 0, 0, "t5_c");
    chk_cnt(0, 0, "t5_mid");
    drive(4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 0, "t5_d");
    drive(4'b0001, 4'b0001, 1'b0, 4'b0001, 1, 0, "t5_e");
    chk_cnt(0, 1, "t5");
    idle(2);

    // 6. Saturation (CW=2) on ch3: 4 matches, count reads 1,2,3,3.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bit m;
      m = (i >= 2) && (i % 2 == 0);
      if (m) chk_cnt(3, (i / 2) - 1, $sformatf("t6_pre%0d", i));
      drive(4'b1000, ((i % 2) == 0) ? 4'b1000 : 4'b0000, 1'b0, 4'b1000, m, 3,
            $sformatf("t6_b%0d", i));
    end
    chk_cnt(3, 3, "t6_sat");
    idle(3);

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_101_scheduler.md
Name: stream_101_scheduler

Overview:
- Shares one "101" serial pattern-detector FSM between NCH independent bitstreams.
- A round-robin arbiter grants one requesting channel per cycle and feeds its bit to the shared detector.
- Each channel's detector state is saved and restored per channel, so detection is identical to NCH private detectors.
- Per-channel saturating match counters are readable through a select port.
- Sits between the serial input front-ends and the status/readout logic.

Parameters:
- NCH, 4, number of input channels (≥2).
- CHW, 2, channel-id width, equals clog2(NCH).
- CW, 8, width of each per-channel match counter.

Ports:
- iCLK  in  1  clock; all logic on the rising edge.
- iRST  in  1  reset, synchronous, active-high.
- iREQ  in  NCH  per-channel request; iBIT[i] is valid while iREQ[i]=1.
- iBIT  in  NCH  per-channel serial data bit.
- iFLUSH  in  1  clears all channel contexts and counters.
- iSEL  in  CHW  counter read select.
- oGNT  out  NCH  one-hot grant (combinational); the bit is consumed on a cycle with iREQ[i]&oGNT[i].
- oMATCH  out  1  registered one-cycle pulse: "101" completed on a channel.
- oMATCH_CH  out  CHW  channel of the match; valid only with oMATCH.
- oCOUNT  out  CW  match count of channel iSEL (combinational read).

Behaviour:
- Reset (iRST=1 at an edge):
  - All contexts go to ST_IDLE; all counters go to 0.
  - oMATCH=0 and oMATCH_CH=0.
  - RR pointer goes to NCH-1, so channel 0 has first priority.
  - oGNT is forced to 0 while iRST=1.
  - Reset mid-pattern discards partial progress.
- Arbitration:
  - Search order is ptr+1, ptr+2, … mod NCH. The first channel with iREQ set is granted.
  - The pointer updates to the granted channel only on a grant cycle.
  - With no requests: oGNT=0 and the pointer holds.
  - Wrap-around: ptr=NCH-1 searches from 0.
- Handshake:
  - A requester holds iREQ/iBIT until it sees oGNT.
  - On the grant cycle the bit is consumed. The requester may present the next bit on the following cycle.
  - A continuous single requester is granted every cycle.
- Detector FSM (per-channel context, 2 bits). Overlapping detection:
  - ST_IDLE: bit 1 → ST_1; bit 0 → ST_IDLE.
  - ST_1: bit 0 → ST_10; bit 1 → ST_1.
  - ST_10: bit 1 → ST_1 and match; bit 0 → ST_IDLE.
  - Only the granted channel's context updates. All others hold.
- Match output:
  - Latency is 1 cycle. If grant cycle t completes "101", then at cycle t+1 oMATCH=1 and oMATCH_CH is the granted id.
  - Otherwise oMATCH=0 next cycle.
- Counters:
  - On a match, the granted channel's counter increments at the same edge that registers oMATCH.
  - The counter saturates at 2^CW-1 and never wraps.
  - oCOUNT = count[iSEL]. A read of the same channel on the same cycle as an increment returns the pre-increment value.
- Flush:
  - iFLUSH=1 forces oGNT=0, so no bit is consumed that cycle.
  - At the edge, all contexts go to ST_IDLE and all counters to 0. oMATCH goes to 0 next cycle. The pointer holds.
  - iRST has priority over iFLUSH.
- Unused encoding 2'b11: treated as ST_IDLE (bit 1 → ST_1, else ST_IDLE).

Decomposition:
- Shared package/header holds:
  - State constants ST_IDLE=2'd0, ST_1=2'd1, ST_10=2'd2.
  - Default NCH/CW.
  - A function next_state(state, bit) returning {match, next}.
- One natural sub-module: rr_arbiter_nch.
  - Inputs: req, advance enable.
  - Output: one-hot gnt plus encoded id.
  - Holds the pointer; synchronous active-high reset on iRST.
- Context regfile, FSM step and counters stay in the top module.

Test Plan:
1. Reset: hold iRST=1 for 2 cycles with iREQ=4'b1111 → oGNT=0, oMATCH=0. After release, the first grant is oGNT=4'b0001 and every oCOUNT reads 0.
2. Single stream: only ch0 requests, bits 1,0,1,0,1 on consecutive cycles → oMATCH pulses with oMATCH_CH=0 one cycle after the 3rd and 5th bits; count[0]=2.
3. Round-robin: iREQ=4'b1111 held → oGNT cycles 0001,0010,0100,1000,0001. Ch2 supplies 1,0,1 on its grants while others supply 1 → exactly one match, oMATCH_CH=2, one cycle after ch2's 3rd grant; count[2]=1, others 0.
4. Context isolation: ch0 sends 1,0; ch1 sends 1; ch0 sends 1 → no match on ch1's bit, then a match with oMATCH_CH=0; count[1]=0.
5. Flush mid-pattern:
   - ch0 sends 1,0; pulse iFLUSH with iREQ[0]=1 → oGNT=0 that cycle.
   - ch0 then sends 1 → no match and count[0]=0.
   - ch0 then sends 0,1 → match.
6. Saturation (CW=2): ch3 sends 1,0,1,0,1,0,1,0,1 (4 matches) → oCOUNT with iSEL=3 reads 1,2,3,3; oMATCH still pulses on the 4th match.
